// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - Mini-SRC opcodes, ALU codes, control-vector bit map and sequencer states
package mini_src_pkg;

  localparam int CTRL_W   = 21;
  localparam int ALU_OP_W = 4;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_ROR = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_ROL = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_NEG = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'd11;

  localparam int PC_OUT      = 0;
  localparam int PC_IN       = 1;
  localparam int INC_PC      = 2;
  localparam int MAR_IN      = 3;
  localparam int MDR_IN      = 4;
  localparam int MDR_OUT     = 5;
  localparam int MEM_READ    = 6;
  localparam int MEM_WRITE   = 7;
  localparam int IR_IN       = 8;
  localparam int Y_IN        = 9;
  localparam int Z_IN        = 10;
  localparam int Z_LO_OUT    = 11;
  localparam int Z_HI_OUT    = 12;
  localparam int HI_IN       = 13;
  localparam int LO_IN       = 14;
  localparam int HI_OUT      = 15;
  localparam int LO_OUT      = 16;
  localparam int C_OUT       = 17;
  localparam int CON_IN      = 18;
  localparam int INPORT_OUT  = 19;
  localparam int OUTPORT_IN  = 20;

  // T-states are consecutive so the sequencer can step with a plain increment.
  typedef enum logic [3:0] {
    RESET_S = 4'd0,
    T0      = 4'd1,
    T1      = 4'd2,
    T2      = 4'd3,
    T3      = 4'd4,
    T4      = 4'd5,
    T5      = 4'd6,
    T6      = 4'd7,
    T7      = 4'd8,
    HALT_S  = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_RTYPE, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST, CLS_MULDIV,
    CLS_UNARY, CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_HALT
  } instr_class_t;

  function automatic state_t last_step(instr_class_t c);
    case (c)
      CLS_RTYPE, CLS_IMM, CLS_LDI: return T5;
      CLS_LD, CLS_ST:              return T7;
      CLS_MULDIV, CLS_BR:          return T6;
      CLS_UNARY:                   return T4;
      default:                     return T3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction inputs and control strobes between sequencer and datapath
interface control_sequencer_if;
  import mini_src_pkg::*;

  logic [31:0]         in_ir;
  logic                in_con_ff;
  logic                in_stop;
  logic                out_gra;
  logic                out_grb;
  logic                out_grc;
  logic                out_read;
  logic                out_write;
  logic                out_base_addr_read;
  logic [CTRL_W-1:0]   out_ctrl;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic                out_run;

  modport master (
    input  in_ir, in_con_ff, in_stop,
    output out_gra, out_grb, out_grc, out_read, out_write, out_base_addr_read,
           out_ctrl, out_alu_op, out_run
  );

  modport slave (
    output in_ir, in_con_ff, in_stop,
    input  out_gra, out_grb, out_grc, out_read, out_write, out_base_addr_read,
           out_ctrl, out_alu_op, out_run
  );

endinterface

// File: rtl/opcode_class_decode.sv
// rtl/opcode_class_decode.sv - maps an opcode to its execute-sequence class and ALU operation
module opcode_class_decode
  import mini_src_pkg::*;
(
  input  logic [4:0]          opcode,
  output instr_class_t        cls,
  output logic [ALU_OP_W-1:0] alu_op
);

  // Loads, stores and branches compute addresses, so they fall through to ADD.
  always_comb begin
    cls    = CLS_NONE;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   cls = CLS_LD;
      OP_LDI:  cls = CLS_LDI;
      OP_ST:   cls = CLS_ST;
      OP_ADD:  begin cls = CLS_RTYPE;  alu_op = ALU_ADD; end
      OP_SUB:  begin cls = CLS_RTYPE;  alu_op = ALU_SUB; end
      OP_AND:  begin cls = CLS_RTYPE;  alu_op = ALU_AND; end
      OP_OR:   begin cls = CLS_RTYPE;  alu_op = ALU_OR;  end
      OP_SHR:  begin cls = CLS_RTYPE;  alu_op = ALU_SHR; end
      OP_SHL:  begin cls = CLS_RTYPE;  alu_op = ALU_SHL; end
      OP_ROR:  begin cls = CLS_RTYPE;  alu_op = ALU_ROR; end
      OP_ROL:  begin cls = CLS_RTYPE;  alu_op = ALU_ROL; end
      OP_ADDI: begin cls = CLS_IMM;    alu_op = ALU_ADD; end
      OP_ANDI: begin cls = CLS_IMM;    alu_op = ALU_AND; end
      OP_ORI:  begin cls = CLS_IMM;    alu_op = ALU_OR;  end
      OP_MUL:  begin cls = CLS_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin cls = CLS_MULDIV; alu_op = ALU_DIV; end
      OP_NEG:  begin cls = CLS_UNARY;  alu_op = ALU_NEG; end
      OP_NOT:  begin cls = CLS_UNARY;  alu_op = ALU_NOT; end
      OP_BR:   cls = CLS_BR;
      OP_JR:   cls = CLS_JR;
      OP_IN:   cls = CLS_IN;
      OP_OUT:  cls = CLS_OUT;
      OP_MFHI: cls = CLS_MFHI;
      OP_MFLO: cls = CLS_MFLO;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Mini-SRC control unit: fetch T0-T2, execute T3-T7
module control_sequencer
  import mini_src_pkg::*;
(
  input  logic                in_clk,
  input  logic                in_rst_n,
  control_sequencer_if.master bus
);

  state_t              state, state_nxt;
  instr_class_t        cls;
  logic [ALU_OP_W-1:0] dec_alu;
  logic [CTRL_W-1:0]   ctrl;
  logic [ALU_OP_W-1:0] alu;
  logic                gra, grb, grc, rd, wr, bar;
  logic                unused_ir;

  assign unused_ir = ^bus.in_ir[26:0];

  opcode_class_decode u_decode (
    .opcode (bus.in_ir[31:27]),
    .cls    (cls),
    .alu_op (dec_alu)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= RESET_S;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET_S: state_nxt = T0;
      T0, T1, T2: state_nxt = state_t'(state + 4'd1);
      T3, T4, T5, T6, T7: begin
        if (state == last_step(cls))
          state_nxt = (cls == CLS_HALT || bus.in_stop) ? HALT_S : T0;
        else
          state_nxt = state_t'(state + 4'd1);
      end
      HALT_S:  state_nxt = HALT_S;
      default: state_nxt = RESET_S;
    endcase
  end

  always_comb begin
    ctrl = '0;
    alu  = ALU_ADD;
    gra  = 1'b0;
    grb  = 1'b0;
    grc  = 1'b0;
    rd   = 1'b0;
    wr   = 1'b0;
    bar  = 1'b0;
    case (state)
      T0: begin ctrl[PC_OUT] = 1'b1; ctrl[MAR_IN] = 1'b1; ctrl[INC_PC] = 1'b1; ctrl[Z_IN] = 1'b1; end
      T1: begin ctrl[MEM_READ] = 1'b1; ctrl[MDR_IN] = 1'b1; end
      T2: begin ctrl[MDR_OUT] = 1'b1; ctrl[IR_IN] = 1'b1; end
      T3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM:       begin grb = 1'b1; rd = 1'b1; ctrl[Y_IN] = 1'b1; end
          CLS_LDI, CLS_LD, CLS_ST:  begin grb = 1'b1; bar = 1'b1; ctrl[Y_IN] = 1'b1; end
          CLS_MULDIV:               begin gra = 1'b1; rd = 1'b1; ctrl[Y_IN] = 1'b1; end
          CLS_UNARY:   begin grb = 1'b1; rd = 1'b1; ctrl[Z_IN] = 1'b1; alu = dec_alu; end
          CLS_BR:      begin gra = 1'b1; rd = 1'b1; ctrl[CON_IN] = 1'b1; end
          CLS_JR:      begin gra = 1'b1; rd = 1'b1; ctrl[PC_IN] = 1'b1; end
          CLS_IN:      begin gra = 1'b1; wr = 1'b1; ctrl[INPORT_OUT] = 1'b1; end
          CLS_OUT:     begin gra = 1'b1; rd = 1'b1; ctrl[OUTPORT_IN] = 1'b1; end
          CLS_MFHI:    begin gra = 1'b1; wr = 1'b1; ctrl[HI_OUT] = 1'b1; end
          CLS_MFLO:    begin gra = 1'b1; wr = 1'b1; ctrl[LO_OUT] = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_RTYPE:  begin grc = 1'b1; rd = 1'b1; ctrl[Z_IN] = 1'b1; alu = dec_alu; end
          CLS_IMM, CLS_LDI, CLS_LD, CLS_ST:
                      begin ctrl[C_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu = dec_alu; end
          CLS_MULDIV: begin grb = 1'b1; rd = 1'b1; ctrl[Z_IN] = 1'b1; alu = dec_alu; end
          CLS_UNARY:  begin ctrl[Z_LO_OUT] = 1'b1; gra = 1'b1; wr = 1'b1; end
          CLS_BR:     begin ctrl[PC_OUT] = 1'b1; ctrl[Y_IN] = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin ctrl[Z_LO_OUT] = 1'b1; gra = 1'b1; wr = 1'b1; end
          CLS_LD, CLS_ST: begin ctrl[Z_LO_OUT] = 1'b1; ctrl[MAR_IN] = 1'b1; end
          CLS_MULDIV:     begin ctrl[Z_LO_OUT] = 1'b1; ctrl[LO_IN] = 1'b1; end
          CLS_BR:         begin ctrl[C_OUT] = 1'b1; ctrl[Z_IN] = 1'b1; alu = ALU_ADD; end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD:     begin ctrl[MEM_READ] = 1'b1; ctrl[MDR_IN] = 1'b1; end
          CLS_ST:     begin gra = 1'b1; rd = 1'b1; ctrl[MDR_IN] = 1'b1; end
          CLS_MULDIV: begin ctrl[Z_HI_OUT] = 1'b1; ctrl[HI_IN] = 1'b1; end
          // The only input-to-output path: branch taken loads the PC.
          CLS_BR:     begin ctrl[Z_LO_OUT] = 1'b1; ctrl[PC_IN] = bus.in_con_ff; end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CLS_LD:  begin ctrl[MDR_OUT] = 1'b1; gra = 1'b1; wr = 1'b1; end
          CLS_ST:  ctrl[MEM_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.out_ctrl           = ctrl;
  assign bus.out_alu_op         = alu;
  assign bus.out_gra            = gra;
  assign bus.out_grb            = grb;
  assign bus.out_grc            = grc;
  assign bus.out_read           = rd;
  assign bus.out_write          = wr;
  assign bus.out_base_addr_read = bar;
  assign bus.out_run            = (state != RESET_S) && (state != HALT_S);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and randomized checks of control_sequencer against a step-list model
module tb_control_sequencer;

  typedef logic [30:0] word_t;

  logic in_clk = 1'b0;
  logic in_rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;

  control_sequencer_if bus();

  control_sequencer dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .bus      (bus)
  );

  always #5 in_clk = ~in_clk;

  // Strobe masks, written out from the out_ctrl bit list.
  localparam logic [20:0] PC_OUT = 21'd1 << 0,  PC_IN = 21'd1 << 1,  INC_PC = 21'd1 << 2;
  localparam logic [20:0] MAR_IN = 21'd1 << 3,  MDR_IN = 21'd1 << 4, MDR_OUT = 21'd1 << 5;
  localparam logic [20:0] MEM_RD = 21'd1 << 6,  MEM_WR = 21'd1 << 7, IR_IN = 21'd1 << 8;
  localparam logic [20:0] Y_IN = 21'd1 << 9,    Z_IN = 21'd1 << 10,  ZLO = 21'd1 << 11;
  localparam logic [20:0] ZHI = 21'd1 << 12,    HI_IN = 21'd1 << 13, LO_IN = 21'd1 << 14;
  localparam logic [20:0] HI_OUT = 21'd1 << 15, LO_OUT = 21'd1 << 16, C_OUT = 21'd1 << 17;
  localparam logic [20:0] CON_IN = 21'd1 << 18, INPORT = 21'd1 << 19, OUTPORT = 21'd1 << 20;
  localparam logic [5:0]  GA = 6'b100000, GB = 6'b010000, GC = 6'b001000;
  localparam logic [5:0]  RD = 6'b000100, WR = 6'b000010, BA = 6'b000001;

  word_t obs;
  assign obs = {bus.out_alu_op, bus.out_ctrl, bus.out_gra, bus.out_grb, bus.out_grc,
                bus.out_read, bus.out_write, bus.out_base_addr_read};

  word_t exp_q[$];

  function automatic word_t w(logic [5:0] s, logic [20:0] c, logic [3:0] a);
    return {a, c, s};
  endfunction

  // ALU codes follow opcode order within each group, so plain offsets give them.
  function automatic logic [3:0] alu_of(logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd10)  return 4'(op - 5'd3);
    if (op == 5'd12)                return 4'd2;
    if (op == 5'd13)                return 4'd3;
    if (op >= 5'd14 && op <= 5'd17) return 4'(op - 5'd6);
    return 4'd0;
  endfunction

  task automatic build(input logic [4:0] op, input logic con);
    logic [3:0] a;
    a = alu_of(op);
    exp_q.delete();
    exp_q.push_back(w(0, PC_OUT | MAR_IN | INC_PC | Z_IN, 0));
    exp_q.push_back(w(0, MEM_RD | MDR_IN, 0));
    exp_q.push_back(w(0, MDR_OUT | IR_IN, 0));
    if (op >= 5'd3 && op <= 5'd10) begin
      exp_q.push_back(w(GB | RD, Y_IN, 0));
      exp_q.push_back(w(GC | RD, Z_IN, a));
      exp_q.push_back(w(GA | WR, ZLO, 0));
    end else if (op <= 5'd2 || (op >= 5'd11 && op <= 5'd13)) begin
      exp_q.push_back(w(GB | ((op >= 5'd11) ? RD : BA), Y_IN, 0));
      exp_q.push_back(w(0, C_OUT | Z_IN, a));
      if (op == 5'd0) begin
        exp_q.push_back(w(0, ZLO | MAR_IN, 0));
        exp_q.push_back(w(0, MEM_RD | MDR_IN, 0));
        exp_q.push_back(w(GA | WR, MDR_OUT, 0));
      end else if (op == 5'd2) begin
        exp_q.push_back(w(0, ZLO | MAR_IN, 0));
        exp_q.push_back(w(GA | RD, MDR_IN, 0));
        exp_q.push_back(w(0, MEM_WR, 0));
      end else begin
        exp_q.push_back(w(GA | WR, ZLO, 0));
      end
    end else if (op == 5'd14 || op == 5'd15) begin
      exp_q.push_back(w(GA | RD, Y_IN, 0));
      exp_q.push_back(w(GB | RD, Z_IN, a));
      exp_q.push_back(w(0, ZLO | LO_IN, 0));
      exp_q.push_back(w(0, ZHI | HI_IN, 0));
    end else if (op == 5'd16 || op == 5'd17) begin
      exp_q.push_back(w(GB | RD, Z_IN, a));
      exp_q.push_back(w(GA | WR, ZLO, 0));
    end else if (op == 5'd18) begin
      exp_q.push_back(w(GA | RD, CON_IN, 0));
      exp_q.push_back(w(0, PC_OUT | Y_IN, 0));
      exp_q.push_back(w(0, C_OUT | Z_IN, 0));
      exp_q.push_back(w(0, ZLO | (con ? PC_IN : 21'd0), 0));
    end else if (op == 5'd19) exp_q.push_back(w(GA | RD, PC_IN, 0));
    else if (op == 5'd21)     exp_q.push_back(w(GA | WR, INPORT, 0));
    else if (op == 5'd22)     exp_q.push_back(w(GA | RD, OUTPORT, 0));
    else if (op == 5'd23)     exp_q.push_back(w(GA | WR, HI_OUT, 0));
    else if (op == 5'd24)     exp_q.push_back(w(GA | WR, LO_OUT, 0));
    else                      exp_q.push_back(w(0, 0, 0));
  endtask

  task automatic chk(input string tag, input word_t o, input word_t e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, obs, '0);
    chk({tag, "_run"}, word_t'(bus.out_run), '0);
  endtask

  task automatic do_reset(input string tag);
    in_rst_n = 1'b0;
    #1;
    chk_idle({tag, "_async"});
    @(posedge in_clk); #1;
    chk_idle({tag, "_held"});
    in_rst_n = 1'b1;
    @(posedge in_clk); #1;
  endtask

  task automatic halt_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk_idle($sformatf("%s_c%0d", tag, i));
      @(posedge in_clk); #1;
    end
  endtask

  // Entered just after the edge that put the DUT into T0; returns likewise.
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic con,
                           input logic stop, input int abort_at, output logic halted);
    int n;
    build(ir[31:27], con);
    n = exp_q.size();
    halted = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.in_ir     = ir;
      bus.in_con_ff = con;
      bus.in_stop   = stop && (k == n - 1);
      if (k == abort_at) begin
        in_rst_n = 1'b0;
        #1;
        chk_idle($sformatf("%s_abort_t%0d", tag, k));
        return;
      end
      #1;
      chk($sformatf("%s_t%0d", tag, k), obs, exp_q[k]);
      chk($sformatf("%s_run_t%0d", tag, k), word_t'(bus.out_run), word_t'(1));
      @(posedge in_clk); #1;
    end
    bus.in_stop = 1'b0;
    halted = (ir[31:27] == 5'd26) || stop;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        h;
    logic [31:0] ir;
    logic        con, stop;
    in_rst_n      = 1'b0;
    bus.in_ir     = '0;
    bus.in_con_ff = 1'b0;
    bus.in_stop   = 1'b0;
    do_reset("reset");

    run_instr("add", 32'h18918000, 1'b0, 1'b0, -1, h);
    run_instr("ld", 32'h00900065, 1'b0, 1'b0, -1, h);
    run_instr("br_nt", 32'h90000000, 1'b0, 1'b0, -1, h);
    run_instr("br_t", 32'h90000000, 1'b1, 1'b0, -1, h);
    run_instr("st", 32'h10900004, 1'b0, 1'b0, -1, h);
    run_instr("jr", 32'h98800000, 1'b0, 1'b0, -1, h);

    run_instr("add_stop", 32'h18918000, 1'b0, 1'b1, -1, h);
    halt_hold("stop_halt", 3);
    do_reset("stop_rst");

    run_instr("mul_abort", 32'h70900000, 1'b0, 1'b0, 4, h);
    do_reset("mul_rst");
    run_instr("after_abort", 32'h18918000, 1'b0, 1'b0, -1, h);

    run_instr("halt", 32'hD0000000, 1'b0, 1'b0, -1, h);
    halt_hold("halt_hold", 20);
    do_reset("halt_rst");

    for (int i = 0; i < 60; i++) begin
      ir   = $urandom;
      con  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 9) == 0);
      if (ir[31:27] == 5'd26 && $urandom_range(0, 3) != 0) ir[31:27] = 5'd3;
      run_instr($sformatf("rnd%0d_op%0d", i, ir[31:27]), ir, con, stop, -1, h);
      if (h) begin
        halt_hold($sformatf("rnd%0d_halt", i), 2);
        do_reset($sformatf("rnd%0d_rst", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired Mini-SRC control unit.
- Steps each instruction through fetch (T0–T2) and execute (T3–T7), one step per clock.
- Drives the register-select strobes (gra/grb/grc), register read/write and base-address-read into the select/encode stage.
- Drives every other datapath strobe as one control vector, plus the ALU operation code.

## Interface
- CTRL_W, 21, width of out_ctrl
- ALU_OP_W, 4, width of out_alu_op
- in_clk  input  1  system clock; all state changes on rising edge
- in_rst_n  input  1  reset, asynchronous and active-low
- in_ir  input  32  instruction register contents; opcode in_ir[31:27]
- in_con_ff  input  1  branch-condition flip-flop output
- in_stop  input  1  request halt at next instruction boundary
- out_gra / out_grb / out_grc  output  1 each  select IR field Ra / Rb / Rc
- out_read  output  1  register file read onto bus
- out_write  output  1  register file write from bus
- out_base_addr_read  output  1  base-address read (R0 reads as 0)
- out_ctrl  output  CTRL_W  datapath strobes, bit map below
- out_alu_op  output  ALU_OP_W  ALU operation, valid when z_in set
- out_run  output  1  1 while executing, 0 in RESET_S/HALT_S

## Operation
- out_ctrl bits 0..20:
  - pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mem_read
  - mem_write, ir_in, y_in, z_in, z_lo_out, z_hi_out, hi_in
  - lo_in, hi_out, lo_out, c_out, con_in, inport_out, outport_in
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, ROR 6, ROL 7, MUL 8, DIV 9, NEG 10, NOT 11.
- addi/andi/ori use ADD/AND/OR.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: mem_read, mdr_in.
  - T2: mdr_out, ir_in.
- Execute, by opcode (last listed step returns to T0):
  - R-type (add 00011 … rol 01010): T3 grb,read,y_in; T4 grc,read,z_in,op; T5 z_lo_out,gra,write.
  - addi/andi/ori (01011–01101), ldi (00001): T3 grb,y_in, plus read (imm) or base_addr_read (ldi); T4 c_out,z_in,op; T5 z_lo_out,gra,write.
  - ld (00000): T3–T4 as ldi; T5 z_lo_out,mar_in; T6 mem_read,mdr_in; T7 mdr_out,gra,write.
  - st (00010): T3–T4 as ldi; T5 z_lo_out,mar_in; T6 gra,read,mdr_in; T7 mem_write.
  - mul/div (01110/01111): T3 gra,read,y_in; T4 grb,read,z_in,op; T5 z_lo_out,lo_in; T6 z_hi_out,hi_in.
  - neg/not (10000/10001): T3 grb,read,z_in,op; T4 z_lo_out,gra,write.
  - br (10010): T3 gra,read,con_in; T4 pc_out,y_in; T5 c_out,z_in,ADD; T6 z_lo_out, plus pc_in only if in_con_ff=1.
  - jr (10011): T3 gra,read,pc_in.
  - in (10101): T3 inport_out,gra,write.
  - out (10110): T3 gra,read,outport_in.
  - mfhi/mflo (10111/11000): T3 hi_out or lo_out, gra,write.
  - halt (11010): T3 no strobes, then HALT_S.
  - nop (11001), jal (10100, not executed in this revision), unassigned opcodes: T3 no strobes, then T0.
- in_stop sampled on the last execute step; if 1, go to HALT_S instead of T0.
- HALT_S is left only by reset.

## Timing
- States: RESET_S, T0..T7, HALT_S.
- Outputs are Moore: combinational from the state register and in_ir, with no input-to-output paths except pc_in from in_con_ff in br/T6.
- in_rst_n low forces RESET_S immediately, including mid-instruction.
- In RESET_S: all outputs 0, out_run=0.
- First rising edge with in_rst_n high moves RESET_S→T0; out_run=1 from then.
- Execute steps decode in_ir; it must stay stable from T3 until the return to T0.
- Instruction latency = last step index + 1 cycles: R-type 6, ld/st 8, jr 4.
- Branch taken or not: same length, 7 cycles.

## Structure
- Shared package/include mini_src_pkg holds:
  - opcode constants
  - ALU op codes
  - out_ctrl bit indices
  - state encoding
- Sub-module opcode_class_decode: combinational, maps in_ir[31:27] to an instruction class and ALU code.
- control_sequencer owns the step register and output decode.

## Test plan
- Reset: hold in_rst_n=0 → all outputs 0, out_run=0. Release → next cycle T0 shows pc_out, mar_in, inc_pc, z_in.
- add R1,R2,R3, in_ir=0x18918000:
  - T3 grb,read,y_in; T4 grc,read,z_in, alu_op=0; T5 gra,write,z_lo_out.
  - Next T0 at cycle 6.
- ld R1,0x65(R2), in_ir=0x00900065: T3 base_addr_read+grb; T5 mar_in; T7 gra,write; 8 cycles total.
- br, in_ir=0x90000000:
  - in_con_ff=0 → no pc_in in T6.
  - in_con_ff=1 → pc_in asserted in T6.
- halt, in_ir=0xD0000000 → HALT_S after T3, out_run=0, holds for 20 cycles. in_stop=1 during add T5 → HALT_S, not T0.
- Pull in_rst_n low during mul T4 → outputs 0 the same cycle without waiting for a clock edge; release → fetch restarts at T0.
